spi_rx_readout_arbiter: RTL
===========================

Name: spi_rx_readout_arbiter

Overview:
- Merges the 32-bit word streams of up to 16 fast SPI receiver channels into one show-ahead FIFO stream for the readout FIFO / SiTCP path.
- Each receiver's FIFO interface (EMPTY/DATA/READ) is one arbiter input.
- Round-robin grant with bounded bursts keeps one chip's frame words contiguous without starving the other chips.
- Single output register stage sustains 1 word/cycle once a grant is held.

Parameters:
- N_CH, 4, number of input channels, 1..16.
- MAX_BURST, 16, max words popped from one channel per grant, 1..255.

Ports:
- BUS_CLK  input  1  sole clock.
- BUS_RST  input  1  reset: asynchronous assertion, active-high.
- CH_EN  input  N_CH  per-channel enable mask; a disabled channel is never granted and is never popped.
- IN_EMPTY  input  N_CH  per-channel FIFO empty flag.
- IN_DATA  input  32*N_CH  per-channel show-ahead data; channel i occupies bits [32*i+31:32*i].
- IN_READ  output  N_CH  per-channel pop strobe; at most one bit set per cycle; combinational.
- FIFO_READ  input  1  downstream pop.
- FIFO_EMPTY  output  1  high when the output register holds no word.
- FIFO_DATA  output  32  output word; valid only while FIFO_EMPTY=0.
- GRANT_ID  output  4  index of the currently or last granted channel.
- BUSY  output  1  high in GRANT state.

Behaviour:
- Reset values: FIFO_EMPTY=1, FIFO_DATA=0, GRANT_ID=N_CH-1 (so channel 0 wins first), BUSY=0, state=IDLE, burst_cnt=0, IN_READ=0.
- Output register:
  - out_valid drives FIFO_EMPTY = !out_valid.
  - load_ok = !out_valid || FIFO_READ.
  - FIFO_READ while FIFO_EMPTY=1 is ignored and has no side effects.
- State IDLE:
  - Search channels GRANT_ID+1, GRANT_ID+2, ... modulo N_CH for the first one with CH_EN=1 and IN_EMPTY=0.
  - On a hit: register GRANT_ID=hit, burst_cnt=0, go to GRANT. No pop in this cycle.
  - No hit: stay in IDLE.
- State GRANT, with g=GRANT_ID:
  - pop = load_ok && !IN_EMPTY[g] && CH_EN[g].
  - IN_READ[g] = pop, combinationally in the same cycle.
  - On pop: FIFO_DATA <= IN_DATA[g], out_valid <= 1, burst_cnt <= burst_cnt+1.
  - If FIFO_READ && !pop: out_valid <= 0.
- Exit from GRANT to IDLE, evaluated every cycle in GRANT:
  - (a) IN_EMPTY[g]=1;
  - (b) CH_EN[g]=0;
  - (c) pop happens with burst_cnt == MAX_BURST-1.
  - Output stalling alone (load_ok=0) never ends a grant.
- Latency:
  - Arbitration costs 1 IDLE cycle per grant.
  - Word appears on FIFO_DATA 1 cycle after its IN_READ pulse.
  - Steady throughput inside a burst is 1 word/cycle with FIFO_READ held high.
- Round-robin fairness: next search always starts at last GRANT_ID+1, so with all N_CH channels busy each channel is served within N_CH grants.
- Boundary conditions:
  - Only one enabled channel with data: it is re-granted after each burst, with one IDLE bubble between bursts.
  - MAX_BURST=1: every word costs 2 cycles.
  - Output register full and FIFO_READ=0: no pop; IN_READ stays 0; words remain in the channel FIFOs; nothing is ever dropped.
  - Simultaneous FIFO_READ and pop: out_valid stays 1 and data is replaced; no bubble.
  - Channel disabled mid-burst: word popped in that cycle (if any) is NOT allowed since pop requires CH_EN; go IDLE.
  - Channel indices >= N_CH are never searched.
  - BUS_RST mid-burst: output word is discarded and the arbiter returns to reset state; channel FIFO contents are untouched.
- Width rules: burst_cnt is 8 bits; GRANT_ID is zero-extended to 4 bits.

Test Plan:
- Reset, then ch0 holds 3 words A0..A2, all others empty, FIFO_READ=1 -> IN_READ[0] pulses 3 consecutive cycles starting the cycle after the IDLE cycle; FIFO_DATA=A0,A1,A2 on consecutive cycles; FIFO_EMPTY=1 afterwards; GRANT_ID=0.
- N_CH=4, MAX_BURST=4, ch0..ch3 each hold 10 words, FIFO_READ=1 -> output order is ch0 x4, ch1 x4, ch2 x4, ch3 x4, ch0 x4, ...; exactly one idle output cycle between bursts; 40 words total, none lost or duplicated.
- Output back-pressure: ch1 holds 5 words, FIFO_READ=0 for 20 cycles -> exactly 1 pop; FIFO_DATA holds word 0; BUSY=1. Then FIFO_READ=1 -> remaining 4 words stream at 1 word/cycle.
- CH_EN=4'b1011 with data in all channels -> ch2 is never popped. Clearing CH_EN[0] during ch0's burst -> IN_READ[0] drops that cycle, and the next grant goes to ch1.
- Random FIFO_READ (50%) and random channel fill, 2000 words -> scoreboard matches each channel's word order; IN_READ is always one-hot or zero; no pop while IN_EMPTY is set.
- Assert BUS_RST during a burst -> FIFO_EMPTY=1 and BUSY=0 immediately (asynchronous); after release, the first grant goes to ch0.

Source files
------------

// File: rtl/spi_rx_readout_arbiter.sv
// Round-robin burst arbiter merging N_CH show-ahead receiver FIFOs
// into a single show-ahead output word register.
module spi_rx_readout_arbiter #(
    parameter int N_CH      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST,
    input  logic [N_CH-1:0]   CH_EN,
    input  logic [N_CH-1:0]   IN_EMPTY,
    input  logic [32*N_CH-1:0] IN_DATA,
    output logic [N_CH-1:0]   IN_READ,
    input  logic              FIFO_READ,
    output logic              FIFO_EMPTY,
    output logic [31:0]       FIFO_DATA,
    output logic [3:0]        GRANT_ID,
    output logic              BUSY
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  grant_n;
    logic [7:0]  burst_cnt;
    logic [7:0]  burst_n;
    logic        out_valid;
    logic        load_ok;
    logic        pop;
    logic        last_word;
    logic        hit;
    logic [3:0]  hit_id;
    logic [4:0]  cand;
    logic [15:0] avail;
    logic [31:0] ch_data [16];

    // Pad to 16 lanes so a 4-bit channel index is always in range
    assign avail = 16'(CH_EN & ~IN_EMPTY);

    for (genvar i = 0; i < 16; i++) begin : g_lane
        if (i < N_CH) begin : g_on
            assign ch_data[i] = IN_DATA[32*i +: 32];
        end else begin : g_off
            assign ch_data[i] = '0;
        end
    end

    // First ready channel after the last grant, wrapping modulo N_CH
    always_comb begin
        hit    = 1'b0;
        hit_id = GRANT_ID;
        cand   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = {1'b0, GRANT_ID} + 5'(k);
            if (cand >= 5'(N_CH)) begin
                cand = cand - 5'(N_CH);
            end
            if (!hit && avail[cand[3:0]]) begin
                hit    = 1'b1;
                hit_id = cand[3:0];
            end
        end
    end

    assign load_ok   = !out_valid || FIFO_READ;
    assign pop       = (state == GRANT) && load_ok && avail[GRANT_ID];
    assign last_word = pop && (burst_cnt == 8'(MAX_BURST - 1));

    always_comb begin
        IN_READ = '0;
        for (int i = 0; i < N_CH; i++) begin
            IN_READ[i] = pop && (GRANT_ID == 4'(i));
        end
    end

    always_comb begin
        state_n = state;
        grant_n = GRANT_ID;
        burst_n = burst_cnt;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    grant_n = hit_id;
                    burst_n = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (pop) begin
                    burst_n = burst_cnt + 8'd1;
                end
                // A stalled output never ends the grant; only source loss or burst end
                if (!avail[GRANT_ID] || last_word) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state     <= IDLE;
            GRANT_ID  <= 4'(N_CH - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            GRANT_ID  <= grant_n;
            burst_cnt <= burst_n;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            out_valid <= 1'b0;
            FIFO_DATA <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            FIFO_DATA <= ch_data[GRANT_ID];
        end else if (FIFO_READ) begin
            out_valid <= 1'b0;
        end
    end

    assign FIFO_EMPTY = !out_valid;
    assign BUSY       = (state == GRANT);

endmodule
